apb_uart_fifo: RTL
==================

Name: apb_uart_fifo

Overview:
APB-slave 8N1 UART, successor to the single-byte blocking UART peripheral. Adds parametrised TX/RX FIFOs, a runtime-programmable baud divisor, a status register with sticky error flags, and an interrupt output. APB transfers never stall: PREADY is high in every access phase. Sits on the APB peripheral bus alongside the other memory-mapped slaves.

Parameters:
BUS_WIDTH, 16, APB data width; must be >= 16.
TX_DEPTH, 8, TX FIFO entries; power of two, >= 2.
RX_DEPTH, 8, RX FIFO entries; power of two, >= 2.
DIV_RESET, 434, clocks per bit after reset (50 MHz / 115200).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
S_PADDR  in  2  register select: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL
S_PWRITE  in  1  1 = write
S_PSELx  in  1  slave select
S_PENABLE  in  1  access phase
S_PWDATA  in  BUS_WIDTH  write data
S_PRDATA  out  BUS_WIDTH  read data
S_PREADY  out  1  transfer complete
tx_wire  out  1  serial out, idle high
rx_wire  in  1  serial in, asynchronous
irq  out  1  level interrupt, registered

Behaviour:
- Reset: both FIFOs empty, sticky flags 0, DIV=DIV_RESET, CTRL=0, TX/RX FSMs IDLE, tx_wire=1, irq=0. Reset mid-frame aborts the frame: tx_wire is 1 after the next edge and any partial RX byte is discarded.
- APB: acc = S_PSELx & S_PENABLE. S_PREADY = acc. S_PRDATA = selected register when acc & !S_PWRITE, else 0 (never Z). Side effects occur exactly once, on the acc clock edge.
- DATA write: push S_PWDATA[7:0] to TX FIFO. If full: drop, set tx_ovf.
- DATA read: returns {0, rx_head[7:0]} and pops. If empty: returns 0, no pop.
- STATUS read: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_ovr, [5] frame_err, [6] tx_ovf, [7] tx_busy (TX FSM not IDLE); upper bits 0.
- STATUS write: write-1-to-clear bits 4..6. A set event in the same cycle as the clear wins.
- DIV: 16-bit read/write. Writes below 4 store 4. A change applies from the next bit boundary, never mid-bit.
- CTRL: [0] rx_ie, [1] txe_ie, [2] err_ie. irq <= (rx_ie & !rx_empty) | (txe_ie & tx_empty & !tx_busy) | (err_ie & (rx_ovr|frame_err|tx_ovf)), registered one cycle.
- FIFOs: circular buffers with log2(DEPTH)+1-bit pointers; full/empty come from the MSB compare. When a push and pop hit the same FIFO in one cycle, both take effect (count unchanged), including when full (pop frees a slot) and when empty (no pop occurs, push occurs).
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO not empty, pop and latch the byte; tx_wire=0 from the next cycle.
  - Each bit lasts DIV cycles. Data is sent LSB first.
  - STOP drives 1 for DIV cycles, then returns to IDLE.
  - Back-to-back bytes have no idle gap beyond the 1 IDLE cycle.
- RX FSM: rx_wire passes a 2-flop synchroniser plus a previous-sample register. States IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge enters START.
  - START: at DIV/2 cycles, sample. If high, it is a glitch; return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits every DIV cycles, LSB first.
  - STOP: sample after DIV cycles. If high, push the byte; if RX is full, drop it and set rx_ovr. If low, discard the byte and set frame_err. Either way, return to IDLE.
  - A same-cycle APB pop on a full RX makes room for the push, so no overrun.
- Latency: a DATA write to an empty TX FIFO makes tx_wire fall 2 cycles after the acc edge.

Test Plan:
- Reset: assert reset for 2 cycles mid-TX frame -> tx_wire=1, STATUS=0x0006, DIV reads 434, irq=0.
- Loopback, DIV=8: write 0x55 then 0xA3, rx_wire tied to tx_wire -> frames of 80 cycles each, start bit 2 cycles after the acc edge. STATUS[2]=0 after frame 2. DATA reads 0x0055, then 0x00A3, then 0x0000 (empty).
- TX overflow, TX_DEPTH=8: 10 writes while the FSM is busy with byte 0 -> 9 bytes transmitted, 10th dropped, STATUS[6]=1. Writing 0x0040 to STATUS clears it.
- RX overrun: inject 9 bytes with RX_DEPTH=8 and no reads -> first 8 are retained in order, rx_ovr=1. Inject a frame with a low stop bit -> frame_err=1, no push.
- Glitch: a 2-cycle low pulse on rx_wire at DIV=16 -> no START acceptance, RX FIFO stays empty, no flags set.
- IRQ and DIV clamp: CTRL=1, receive 1 byte -> irq=1 one cycle after the push; pop -> irq=0 one cycle later. Write DIV=2 -> reads back 4.

Source files
------------

// File: rtl/apb_uart_fifo_if.sv
// APB peripheral-bus bundle for apb_uart_fifo; the slave answers every access phase with PREADY=1.
interface apb_uart_fifo_if #(
   parameter int BUS_WIDTH = 16
);
   logic [1:0]           S_PADDR;
   logic                 S_PWRITE;
   logic                 S_PSELx;
   logic                 S_PENABLE;
   logic [BUS_WIDTH-1:0] S_PWDATA;
   logic [BUS_WIDTH-1:0] S_PRDATA;
   logic                 S_PREADY;

   modport master (output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
                   input  S_PRDATA, S_PREADY);
   modport slave  (input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
                   output S_PRDATA, S_PREADY);
endinterface

// File: rtl/apb_uart_fifo.sv
// APB 8N1 UART with TX/RX FIFOs, programmable divisor, sticky flags and irq; tx_wire falls 2 cycles
// after a DATA write to an idle TX. No APB stall: a full TX FIFO drops writes, a full RX FIFO drops frames.
module apb_uart_fifo #(
   parameter int BUS_WIDTH = 16,
   parameter int TX_DEPTH  = 8,
   parameter int RX_DEPTH  = 8,
   parameter int DIV_RESET = 434
) (
   input  logic           clk,
   input  logic           reset,
   apb_uart_fifo_if.slave bus,
   output logic           tx_wire,
   input  logic           rx_wire,
   output logic           irq
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_ONE = 1;
   localparam logic [RAW:0] RX_ONE = 1;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

   logic acc, wr, rd;
   assign acc = bus.S_PSELx & bus.S_PENABLE;
   assign wr  = acc & bus.S_PWRITE;
   assign rd  = acc & ~bus.S_PWRITE;
   assign bus.S_PREADY = acc;

   logic [15:0] div;
   logic [2:0]  ctrl;
   logic        rx_ovr, frame_err, tx_ovf;
   logic [2:0]  sts_clr;
   assign sts_clr = (wr && bus.S_PADDR == 2'd1) ? bus.S_PWDATA[6:4] : 3'b000;

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wp, tx_rp;
   logic         tx_empty, tx_full, tx_push_req, tx_push, tx_pop;
   assign tx_empty    = tx_wp == tx_rp;
   assign tx_full     = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
   assign tx_push_req = wr && bus.S_PADDR == 2'd0;
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);

   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wp, rx_rp;
   logic         rx_empty, rx_full, rx_push_req, rx_push, rx_pop, ferr_set;
   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
   assign rx_pop   = rd && bus.S_PADDR == 2'd0 && !rx_empty;
   assign rx_push  = rx_push_req && (!rx_full || rx_pop);

   uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
   logic [15:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
   logic [7:0]  tx_sh, tx_sh_n, rx_sh, rx_sh_n;
   logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n;
   logic        rx_s1, rx_s2, rx_s3, tx_busy;
   assign tx_busy = tx_state != ST_IDLE;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= bus.S_PWDATA[7:0];
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         div       <= 16'(DIV_RESET);
         ctrl      <= '0;
         rx_ovr    <= 1'b0;
         frame_err <= 1'b0;
         tx_ovf    <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + TX_ONE;
         if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
         if (rx_push) rx_wp <= rx_wp + RX_ONE;
         if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
         if (wr && bus.S_PADDR == 2'd2)
            div <= (bus.S_PWDATA[15:0] < 16'd4) ? 16'd4 : bus.S_PWDATA[15:0];
         if (wr && bus.S_PADDR == 2'd3) ctrl <= bus.S_PWDATA[2:0];
         // set terms are OR'd after the clear so a same-cycle event survives
         rx_ovr    <= (rx_push_req && !rx_push) || (rx_ovr && !sts_clr[0]);
         frame_err <= ferr_set || (frame_err && !sts_clr[1]);
         tx_ovf    <= (tx_push_req && !tx_push) || (tx_ovf && !sts_clr[2]);
         irq       <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty && !tx_busy) ||
                      (ctrl[2] && (rx_ovr || frame_err || tx_ovf));
      end
   end

   always_comb begin
      bus.S_PRDATA = '0;
      if (rd) begin
         case (bus.S_PADDR)
            2'd0:    if (!rx_empty) bus.S_PRDATA[7:0] = rx_mem[rx_rp[RAW-1:0]];
            2'd1:    bus.S_PRDATA[7:0] = {tx_busy, tx_ovf, frame_err, rx_ovr,
                                          rx_full, rx_empty, tx_empty, tx_full};
            2'd2:    bus.S_PRDATA[15:0] = div;
            default: bus.S_PRDATA[2:0] = ctrl;
         endcase
      end
   end

   // Bit timers count down and reload from div at each bit boundary, so a DIV write never cuts a bit short.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_sh_n    = tx_sh;
      tx_bit_n   = tx_bit;
      tx_pop     = 1'b0;
      case (tx_state)
         ST_IDLE: if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_mem[tx_rp[TAW-1:0]];
            tx_cnt_n   = div - 16'd1;
            tx_state_n = ST_START;
         end
         ST_START: if (tx_cnt == '0) begin
            tx_cnt_n   = div - 16'd1;
            tx_bit_n   = 3'd0;
            tx_state_n = ST_DATA;
         end else tx_cnt_n = tx_cnt - 16'd1;
         ST_DATA: if (tx_cnt == '0) begin
            tx_cnt_n = div - 16'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            tx_bit_n = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state_n = ST_STOP;
         end else tx_cnt_n = tx_cnt - 16'd1;
         ST_STOP: if (tx_cnt == '0) tx_state_n = ST_IDLE;
                  else tx_cnt_n = tx_cnt - 16'd1;
         default: tx_state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_state_n  = rx_state;
      rx_cnt_n    = rx_cnt;
      rx_sh_n     = rx_sh;
      rx_bit_n    = rx_bit;
      rx_push_req = 1'b0;
      ferr_set    = 1'b0;
      case (rx_state)
         ST_IDLE: if (rx_s3 && !rx_s2) begin
            rx_cnt_n   = {1'b0, div[15:1]} - 16'd1;
            rx_state_n = ST_START;
         end
         ST_START: if (rx_cnt == '0) begin
            if (rx_s2) rx_state_n = ST_IDLE;
            else begin
               rx_cnt_n   = div - 16'd1;
               rx_bit_n   = 3'd0;
               rx_state_n = ST_DATA;
            end
         end else rx_cnt_n = rx_cnt - 16'd1;
         ST_DATA: if (rx_cnt == '0) begin
            rx_cnt_n = div - 16'd1;
            rx_sh_n  = {rx_s2, rx_sh[7:1]};
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = ST_STOP;
         end else rx_cnt_n = rx_cnt - 16'd1;
         ST_STOP: if (rx_cnt == '0) begin
            if (rx_s2) rx_push_req = 1'b1;
            else       ferr_set    = 1'b1;
            rx_state_n = ST_IDLE;
         end else rx_cnt_n = rx_cnt - 16'd1;
         default: rx_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= ST_IDLE;
         tx_cnt   <= '0;
         tx_sh    <= '0;
         tx_bit   <= '0;
         tx_wire  <= 1'b1;
         rx_state <= ST_IDLE;
         rx_cnt   <= '0;
         rx_sh    <= '0;
         rx_bit   <= '0;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_sh    <= tx_sh_n;
         tx_bit   <= tx_bit_n;
         tx_wire  <= (tx_state == ST_START) ? 1'b0 :
                     (tx_state == ST_DATA)  ? tx_sh[0] : 1'b1;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_sh    <= rx_sh_n;
         rx_bit   <= rx_bit_n;
         rx_s1    <= rx_wire;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
      end
   end
endmodule
